// File: rtl/dpll_ctrl_div.sv
// Digital PLL divider/phase controller: counts clk_d1/clk_d2 pulses into a
// symbol divider, applies advance/retard corrections and tracks lock.
module dpll_ctrl_div #(
    parameter int DIV_W      = 3,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 2
) (
    input  logic rst,
    input  logic clk32,
    input  logic en,
    input  logic clk_d1,
    input  logic clk_d2,
    input  logic pd_before,
    input  logic pd_after,
    output logic clk_i,
    output logic clk_q,
    output logic sym_stb,
    output logic adv,
    output logic ret,
    output logic locked
);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t      state, state_nxt;
    logic [DIV_W-1:0] c;
    logic [DIV_W:0]   sum;
    logic [1:0]       inc;
    logic [7:0]       run, run_nxt, run_up;
    logic             eff_b, eff_a;
    logic             do_adv, do_ret;
    logic             carry;
    logic             flag, flag_nxt;
    logic             corrected;

    // Conflicting phase-detector levels cancel each other out.
    assign eff_b = pd_before & ~pd_after;
    assign eff_a = pd_after & ~pd_before;

    assign do_ret = clk_d1 & eff_b;
    assign do_adv = clk_d2 & eff_a;

    assign inc   = {1'b0, clk_d1 & ~eff_b} + {1'b0, do_adv};
    assign sum   = {1'b0, c} + (DIV_W+1)'(inc);
    assign carry = sum[DIV_W];

    // A correction in the wrap cycle still belongs to the ending symbol.
    assign corrected = flag | do_adv | do_ret;
    assign run_up    = (run == 8'hFF) ? run : run + 8'd1;

    assign locked = (state == LOCKED);

    // Lock FSM next state and per-symbol correction flag.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        flag_nxt  = flag;
        if (en) begin
            if (carry) begin
                flag_nxt = 1'b0;
                case (state)
                    UNLOCKED: begin
                        if (corrected) begin
                            run_nxt = 8'd0;
                        end else if (run_up >= 8'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            run_nxt   = 8'd0;
                        end else begin
                            run_nxt = run_up;
                        end
                    end
                    LOCKED: begin
                        if (!corrected) begin
                            run_nxt = 8'd0;
                        end else if (run_up >= 8'(UNLOCK_CNT)) begin
                            state_nxt = UNLOCKED;
                            run_nxt   = 8'd0;
                        end else begin
                            run_nxt = run_up;
                        end
                    end
                    default: begin
                        state_nxt = UNLOCKED;
                        run_nxt   = 8'd0;
                    end
                endcase
            end else begin
                flag_nxt = corrected;
            end
        end
    end

    // Divider, recovered clocks, event pulses and lock state registers.
    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            c       <= '0;
            clk_i   <= 1'b0;
            clk_q   <= 1'b0;
            sym_stb <= 1'b0;
            adv     <= 1'b0;
            ret     <= 1'b0;
            state   <= UNLOCKED;
            run     <= 8'd0;
            flag    <= 1'b0;
        end else begin
            sym_stb <= en & carry;
            adv     <= en & do_adv;
            ret     <= en & do_ret;
            if (en) begin
                c     <= sum[DIV_W-1:0];
                clk_i <= ~sum[DIV_W-1];
                clk_q <= sum[DIV_W-1];
            end
            state <= state_nxt;
            run   <= run_nxt;
            flag  <= flag_nxt;
        end
    end

endmodule

// File: tb/tb_dpll_ctrl_div.sv
// Self-checking bench for dpll_ctrl_div: vector table applied through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_dpll_ctrl_div;

    logic rst, clk32, en, clk_d1, clk_d2, pd_before, pd_after;
    logic clk_i, clk_q, sym_stb, adv, ret, locked;

    typedef struct {
        logic       en, d1, d2, pb, pa;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sbq[$];
    logic [2:0] tc;
    int         checks = 0;
    int         errors = 0;

    dpll_ctrl_div #(
        .DIV_W(3),
        .LOCK_CNT(4),
        .UNLOCK_CNT(2)
    ) dut (
        .rst(rst),
        .clk32(clk32),
        .en(en),
        .clk_d1(clk_d1),
        .clk_d2(clk_d2),
        .pd_before(pd_before),
        .pd_after(pd_after),
        .clk_i(clk_i),
        .clk_q(clk_q),
        .sym_stb(sym_stb),
        .adv(adv),
        .ret(ret),
        .locked(locked)
    );

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] got;
        got = {clk_i, clk_q, sym_stb, adv, ret, locked};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got i/q/stb/adv/ret/lk=%b want %b", nm, got, exp);
        end
    endtask

    task automatic add(input logic e, d1, d2, pb, pa,
                       input logic i, q, s, a, r, l);
        vec_t v;
        v.en = e; v.d1 = d1; v.d2 = d2; v.pb = pb; v.pa = pa;
        v.exp = {i, q, s, a, r, l};
        vecs.push_back(v);
    endtask

    // n clean clk_d1 pulses; locked reads lb before pulse lp, la from it on.
    task automatic pulse_seq(input int n, input int lp,
                             input logic lb, input logic la);
        logic lk;
        for (int k = 1; k <= n; k++) begin
            tc = tc + 3'd1;
            lk = (k >= lp) ? la : lb;
            add(1, 1, 0, 0, 0, ~tc[2], tc[2], tc == 3'd0, 0, 0, lk);
        end
    endtask

    task automatic drive(input logic e, d1, d2, pb, pa);
        en = e; clk_d1 = d1; clk_d2 = d2; pd_before = pb; pd_after = pa;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tc = 3'd0;
        #1;
        check("reset_state", 6'b000000);

        // 8 nominal pulses: clocks follow the divider MSB, one wrap strobe.
        pulse_seq(8, 9, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Double-increment wrap from c=6 with an advance.
        pulse_seq(6, 9, 0, 0);
        add(1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0);
        tc = 3'd0;
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Conflicting detector levels: only clk_d1 counts, no corrections.
        add(1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        tc = 3'd2;
        // Retard at c=2: three ret pulses, divider holds.
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        pulse_seq(6, 9, 0, 0);
        // Four clean symbols lock on the last wrap.
        pulse_seq(32, 32, 0, 1);
        // Two corrected symbols unlock on the second wrap.
        add(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1);
        tc = 3'd1;
        pulse_seq(7, 8, 1, 1);
        add(1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1);
        tc = 3'd1;
        pulse_seq(7, 7, 1, 0);
        // Enable low: state holds, no pulses.
        pulse_seq(3, 9, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        pulse_seq(1, 9, 0, 0);
        // Relock, then stop at c=5 for the reset test.
        pulse_seq(4, 9, 0, 0);
        pulse_seq(24, 24, 0, 1);
        pulse_seq(5, 9, 1, 1);

        @(negedge clk32);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk32);
            if (sbq.size() > 0) check($sformatf("vec%0d", i - 1), sbq.pop_front());
            drive(vecs[i].en, vecs[i].d1, vecs[i].d2, vecs[i].pb, vecs[i].pa);
            sbq.push_back(vecs[i].exp);
        end
        @(negedge clk32);
        drive(1, 0, 0, 0, 0);
        if (sbq.size() > 0) check("vec_last", sbq.pop_front());

        // Async reset at c=5 while locked clears outputs without an edge.
        check("pre_reset_locked", 6'b010001);
        #2 rst = 1'b1;
        #1 check("async_reset", 6'b000000);
        @(negedge clk32);
        rst = 1'b0;
        drive(1, 1, 0, 0, 0);
        @(negedge clk32);
        check("first_after_reset", 6'b100000);
        drive(1, 0, 0, 0, 0);
        @(negedge clk32);
        check("idle_after_reset", 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
